// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU time-share arbiter: ALU select codes
// (as produced by ALU control decode), FSM state encodings and width defaults.
package alu_share_arbiter_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int SEL_W_DEF = 4;

  // ALU select codes, bit 3 distinguishes SUB/SRA from ADD/SRL.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // Operation lifecycle: wait for a request, drive the ALU, hold the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of the requester, response and ALU-side signals of the arbiter.
// Handshake semantics: a request transfers on a rising edge where
// reqK_valid && reqK_ready; a response transfers on a rising edge where
// respK_valid && respK_ready. Valid may be withdrawn before ready, which
// cancels the request; while valid is held, operands must not change.
interface alu_share_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [XLEN-1:0]  req0_a;
  logic [XLEN-1:0]  req0_b;
  logic [SEL_W-1:0] req0_sel;
  logic             req1_valid;
  logic             req1_ready;
  logic [XLEN-1:0]  req1_a;
  logic [XLEN-1:0]  req1_b;
  logic [SEL_W-1:0] req1_sel;
  logic             resp0_valid;
  logic             resp1_valid;
  logic             resp0_ready;
  logic             resp1_ready;
  logic [XLEN-1:0]  resp_data;
  logic             resp_zero;
  logic [XLEN-1:0]  alu_a;
  logic [XLEN-1:0]  alu_b;
  logic [SEL_W-1:0] alu_sel;
  logic [XLEN-1:0]  alu_result;
  logic             alu_zero;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  resp0_ready, resp1_ready, alu_result, alu_zero,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
    output resp_data, resp_zero, alu_a, alu_b, alu_sel
  );

  // Requesters plus ALU side, as seen from the surrounding pipeline.
  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output resp0_ready, resp1_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
    input  resp_data, resp_zero, alu_a, alu_b, alu_sel
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant. Requester 1 wins when it is the only one
// valid, or when both are valid and requester 0 was served last. In every
// other enabled case requester 0 holds the grant, including when nobody is
// valid, so a fresh requester-0 operation is accepted in its first cycle.
// At most one grant is ever high.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  input  logic enable,
  output logic gnt0,
  output logic gnt1
);

  // Grant decision, purely combinational.
  always_comb begin
    gnt1 = enable && valid1 && (!valid0 || !last_grant);
    gnt0 = enable && !gnt1;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one integer ALU between the execute operand path (requester 0)
// and the branch/address path (requester 1). An accepted operation spends
// one cycle driving the ALU from registered operands, then the captured
// result and zero flag are held for the owner until it takes them.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_arbiter_if.slave   bus,
  output state_t               dbg_state
);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [XLEN-1:0]  op_a_q, op_a_d;
  logic [XLEN-1:0]  op_b_q, op_b_d;
  logic [SEL_W-1:0] op_sel_q, op_sel_d;
  logic [XLEN-1:0]  resp_data_q, resp_data_d;
  logic             resp_zero_q, resp_zero_d;

  logic             gnt0;
  logic             gnt1;
  logic             arb_en;
  logic             alu_busy;

  // Readies only exist in IDLE; gating with rst_n keeps them low while reset
  // is held, not just after the state has been forced.
  assign arb_en = (state_q == ST_IDLE) && rst_n;

  rr_arb2 u_rr_arb2 (
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .last_grant (last_grant_q),
    .enable     (arb_en),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  // Next-state and datapath capture for accept / execute / respond.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_sel_d     = op_sel_q;
    resp_data_d  = resp_data_q;
    resp_zero_d  = resp_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt0 && bus.req0_valid) begin
          op_a_d       = bus.req0_a;
          op_b_d       = bus.req0_b;
          op_sel_d     = bus.req0_sel;
          owner_d      = 1'b0;
          last_grant_d = 1'b0;
          state_d      = ST_EXEC;
        end else if (gnt1) begin
          op_a_d       = bus.req1_a;
          op_b_d       = bus.req1_b;
          op_sel_d     = bus.req1_sel;
          owner_d      = 1'b1;
          last_grant_d = 1'b1;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        resp_data_d = bus.alu_result;
        resp_zero_d = bus.alu_zero;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Only the owner's ready releases the result.
        if (owner_q ? bus.resp1_ready : bus.resp0_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and data registers; last_grant resets to 1 so req0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= '0;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_sel_q     <= op_sel_d;
      resp_data_q  <= resp_data_d;
      resp_zero_q  <= resp_zero_d;
    end
  end

  // ALU inputs carry the captured operation only while one is in flight;
  // otherwise they sit at zero operands with the ADD select.
  assign alu_busy       = (state_q == ST_EXEC) || (state_q == ST_RESP);
  assign bus.alu_a      = alu_busy ? op_a_q   : '0;
  assign bus.alu_b      = alu_busy ? op_b_q   : '0;
  assign bus.alu_sel    = alu_busy ? op_sel_q : SEL_W'(ALU_ADD);

  assign bus.req0_ready  = gnt0;
  assign bus.req1_ready  = gnt1;
  assign bus.resp0_valid = (state_q == ST_RESP) && !owner_q;
  assign bus.resp1_valid = (state_q == ST_RESP) &&  owner_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_zero   = resp_zero_q;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int XLEN  = 32;
  localparam int SEL_W = 4;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  alu_share_arbiter_if #(.XLEN(XLEN), .SEL_W(SEL_W)) bus ();

  alu_share_arbiter #(.XLEN(XLEN), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_cmp;
  int n_fail;

  // Scoreboard entries: {owner, zero, result}.
  logic [XLEN+1:0] exp_q[$];

  // Model's view of which requester was served last.
  logic m_lg;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench ALU: ADD and SUB are the only selects used.
  logic [XLEN-1:0] alu_tmp;
  always_comb begin
    alu_tmp = (bus.alu_sel == ALU_SUB) ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);
    bus.alu_result = alu_tmp;
    bus.alu_zero   = (alu_tmp == '0);
  end

  function automatic logic [XLEN:0] ref_alu(input logic [SEL_W-1:0] sel,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = (sel == 4'b1000) ? a - b : a + b;
    return {(r == 0), r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.req0_valid  = 1'b0;
    bus.req1_valid  = 1'b0;
    bus.req0_a      = '0;
    bus.req0_b      = '0;
    bus.req0_sel    = '0;
    bus.req1_a      = '0;
    bus.req1_b      = '0;
    bus.req1_sel    = '0;
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_lg = 1'b1;
  endtask

  task automatic drive_req0(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [SEL_W-1:0] sel);
    bus.req0_valid = 1'b1;
    bus.req0_a = a;
    bus.req0_b = b;
    bus.req0_sel = sel;
  endtask

  task automatic drive_req1(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [SEL_W-1:0] sel);
    bus.req1_valid = 1'b1;
    bus.req1_a = a;
    bus.req1_b = b;
    bus.req1_sel = sel;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req0_ready: got %0b want 0", bus.req0_ready); end
    n_cmp++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req1_ready: got %0b want 0", bus.req1_ready); end
    n_cmp++; if ({bus.resp0_valid, bus.resp1_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_resp_valid: got %0b%0b want 00", bus.resp0_valid, bus.resp1_valid); end
    n_cmp++; if ({bus.resp_zero, bus.resp_data} !== '0) begin n_fail++; $display("FAIL rst_resp: got %0h/%0b want 0/0", bus.resp_data, bus.resp_zero); end
    n_cmp++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== '0) begin n_fail++; $display("FAIL rst_alu: got a=%0h b=%0h sel=%0h want 0", bus.alu_a, bus.alu_b, bus.alu_sel); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    m_lg = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    drive_req0(32'd5, 32'd3, ALU_ADD);
    #1;
    n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %0b%0b want 10", bus.req0_ready, bus.req1_ready); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    n_cmp++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd3) begin n_fail++; $display("FAIL single_alu_ops: got %0d,%0d want 5,3", bus.alu_a, bus.alu_b); end
    n_cmp++; if (bus.resp0_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_resp: got %0b want 0", bus.resp0_valid); end
    @(negedge clk);
    #1;
    n_cmp++; if ({bus.resp0_valid, bus.resp1_valid} !== 2'b10) begin n_fail++; $display("FAIL single_resp_valid: got %0b%0b want 10", bus.resp0_valid, bus.resp1_valid); end
    n_cmp++; if (bus.resp_data !== 32'd8 || bus.resp_zero !== 1'b0) begin n_fail++; $display("FAIL single_resp_data: got %0d/%0b want 8/0", bus.resp_data, bus.resp_zero); end
    bus.resp0_ready = 1'b1;
    @(negedge clk);
    bus.resp0_ready = 1'b0;
    #1;
    n_cmp++; if (dbg_state !== ST_IDLE || bus.resp0_valid !== 1'b0) begin n_fail++; $display("FAIL single_release: got state=%0d v=%0b want %0d/0", dbg_state, bus.resp0_valid, ST_IDLE); end
    n_cmp++; if (bus.alu_a !== '0 || bus.alu_sel !== '0) begin n_fail++; $display("FAIL single_alu_quiet: got a=%0h sel=%0h want 0", bus.alu_a, bus.alu_sel); end
    m_lg = 1'b0;
  endtask

  task automatic test_tie();
    apply_reset();
    @(negedge clk);
    drive_req0(32'd10, 32'd4, ALU_SUB);
    drive_req1(32'd7, 32'd7, ALU_SUB);
    #1;
    n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL tie_first_grant: got %0b%0b want 10", bus.req0_ready, bus.req1_ready); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    n_cmp++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL tie_exec_ready: got %0b want 0", bus.req1_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.resp0_valid !== 1'b1 || bus.resp_data !== 32'd6) begin n_fail++; $display("FAIL tie_resp0: got v=%0b d=%0d want 1/6", bus.resp0_valid, bus.resp_data); end
    bus.resp0_ready = 1'b1;
    @(negedge clk);
    bus.resp0_ready = 1'b0;
    #1;
    n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin n_fail++; $display("FAIL tie_second_grant: got %0b%0b want 01", bus.req0_ready, bus.req1_ready); end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if ({bus.resp0_valid, bus.resp1_valid} !== 2'b01) begin n_fail++; $display("FAIL tie_resp1_valid: got %0b%0b want 01", bus.resp0_valid, bus.resp1_valid); end
    n_cmp++; if (bus.resp_data !== 32'd0 || bus.resp_zero !== 1'b1) begin n_fail++; $display("FAIL tie_resp1_data: got %0d/%0b want 0/1", bus.resp_data, bus.resp_zero); end
    bus.resp1_ready = 1'b1;
    @(negedge clk);
    bus.resp1_ready = 1'b0;
    m_lg = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0]  a, b;
    logic [SEL_W-1:0] sel;
    logic [XLEN:0]    exp;
    a = $urandom();
    b = $urandom();
    sel = ($urandom_range(0, 1) != 0) ? ALU_SUB : ALU_ADD;
    exp = ref_alu(sel, a, b);
    @(negedge clk);
    drive_req0(a, b, sel);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    drive_req1($urandom(), $urandom(), ALU_ADD);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (bus.resp0_valid !== 1'b1 || {bus.resp_zero, bus.resp_data} !== exp) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%0b d=%0h z=%0b want 1/%0h/%0b", i, bus.resp0_valid, bus.resp_data, bus.resp_zero, exp[XLEN-1:0], exp[XLEN]); end
      n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d]: got %0b%0b want 00", i, bus.req0_ready, bus.req1_ready); end
      @(negedge clk);
    end
    bus.resp0_ready = 1'b1;
    @(negedge clk);
    bus.resp0_ready = 1'b0;
    #1;
    n_cmp++; if (dbg_state !== ST_IDLE || bus.resp0_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got state=%0d v=%0b want %0d/0", dbg_state, bus.resp0_valid, ST_IDLE); end
    n_cmp++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_next_ready: got %0b want 1", bus.req1_ready); end
    bus.req1_valid = 1'b0;
    m_lg = 1'b0;
  endtask

  task automatic test_fairness();
    logic exp_who;
    logic who;
    logic reload0, reload1;
    int   n_acc, last_cyc, cyc;
    logic [XLEN+1:0] ent;
    exp_who = !m_lg;
    n_acc = 0; last_cyc = 0; cyc = 0;
    reload0 = 1'b1; reload1 = 1'b1;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    while (n_acc < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (reload0) drive_req0($urandom(), $urandom(), ($urandom_range(0, 1) != 0) ? ALU_SUB : ALU_ADD);
      if (reload1) drive_req1($urandom(), $urandom(), ($urandom_range(0, 1) != 0) ? ALU_SUB : ALU_ADD);
      reload0 = 1'b0; reload1 = 1'b0;
      #1;
      if (bus.resp0_valid || bus.resp1_valid) begin
        ent = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_cmp++; if ({bus.resp1_valid, bus.resp_zero, bus.resp_data} !== ent) begin n_fail++; $display("FAIL fair_resp: got own=%0b z=%0b d=%0h want own=%0b z=%0b d=%0h", bus.resp1_valid, bus.resp_zero, bus.resp_data, ent[XLEN+1], ent[XLEN], ent[XLEN-1:0]); end
      end
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
        who = bus.req1_valid && bus.req1_ready;
        n_cmp++; if (who !== exp_who) begin n_fail++; $display("FAIL fair_order[%0d]: got %0b want %0b", n_acc, who, exp_who); end
        if (n_acc > 0) begin
          n_cmp++; if (cyc - last_cyc != 3) begin n_fail++; $display("FAIL fair_spacing[%0d]: got %0d want 3", n_acc, cyc - last_cyc); end
        end
        if (who) exp_q.push_back({1'b1, ref_alu(bus.req1_sel, bus.req1_a, bus.req1_b)});
        else     exp_q.push_back({1'b0, ref_alu(bus.req0_sel, bus.req0_a, bus.req0_b)});
        if (who) reload1 = 1'b1; else reload0 = 1'b1;
        m_lg = who;
        exp_who = !exp_who;
        last_cyc = cyc;
        n_acc++;
      end
    end
    n_cmp++; if (n_acc != 6) begin n_fail++; $display("FAIL fair_timeout: got %0d ops want 6", n_acc); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      #1;
      if (bus.resp0_valid || bus.resp1_valid) begin
        ent = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_cmp++; if ({bus.resp1_valid, bus.resp_zero, bus.resp_data} !== ent) begin n_fail++; $display("FAIL fair_drain: got own=%0b d=%0h want own=%0b d=%0h", bus.resp1_valid, bus.resp_data, ent[XLEN+1], ent[XLEN-1:0]); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL fair_missing_resp: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_req0($urandom(), $urandom(), ALU_ADD);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== '0) begin n_fail++; $display("FAIL midrst_alu: got a=%0h b=%0h sel=%0h want 0", bus.alu_a, bus.alu_b, bus.alu_sel); end
    n_cmp++; if ({bus.resp0_valid, bus.resp1_valid, bus.req0_ready, bus.req1_ready} !== 4'b0) begin n_fail++; $display("FAIL midrst_flags: got %0b%0b%0b%0b want 0000", bus.resp0_valid, bus.resp1_valid, bus.req0_ready, bus.req1_ready); end
    n_cmp++; if (bus.resp_data !== '0 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midrst_state: got d=%0h st=%0d want 0/%0d", bus.resp_data, dbg_state, ST_IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    m_lg = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (bus.resp0_valid !== 1'b0 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midrst_no_resp: got v=%0b st=%0d want 0/%0d", bus.resp0_valid, dbg_state, ST_IDLE); end
    @(negedge clk);
    drive_req1(32'd1, 32'd2, ALU_ADD);
    #1;
    n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin n_fail++; $display("FAIL midrst_req1_ready: got %0b%0b want 01", bus.req0_ready, bus.req1_ready); end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (bus.resp1_valid !== 1'b1 || bus.resp_data !== 32'd3) begin n_fail++; $display("FAIL midrst_resp1: got v=%0b d=%0d want 1/3", bus.resp1_valid, bus.resp_data); end
    m_lg = 1'b1;
  endtask

  // Continues from test_reset_mid: requester 1 owns a pending response.
  task automatic test_non_owner();
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (bus.resp1_valid !== 1'b1 || bus.resp0_valid !== 1'b0 || dbg_state !== ST_RESP) begin n_fail++; $display("FAIL nonowner_hold[%0d]: got v1=%0b v0=%0b st=%0d want 1/0/%0d", i, bus.resp1_valid, bus.resp0_valid, dbg_state, ST_RESP); end
    end
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b1;
    @(negedge clk);
    bus.resp1_ready = 1'b0;
    #1;
    n_cmp++; if (dbg_state !== ST_IDLE || bus.resp1_valid !== 1'b0) begin n_fail++; $display("FAIL nonowner_release: got st=%0d v1=%0b want %0d/0", dbg_state, bus.resp1_valid, ST_IDLE); end
  endtask

  // Randomized traffic against a transaction model: an accepted operation is
  // in flight for one cycle, then its result is offered until the owner
  // takes it; nothing is accepted while an operation is outstanding.
  task automatic test_random();
    logic            m_busy, m_owner, winner, e_r0, e_r1, e_v0, e_v1;
    int              m_age;
    logic [XLEN-1:0] m_a, m_b;
    logic [SEL_W-1:0] m_sel;
    logic [XLEN:0]   m_res;
    m_busy = 1'b0; m_owner = 1'b0; m_age = 0;
    m_a = '0; m_b = '0; m_sel = '0; m_res = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      bus.req0_valid = ($urandom_range(0, 1) != 0);
      bus.req1_valid = ($urandom_range(0, 1) != 0);
      bus.req0_a = $urandom();
      bus.req0_b = ($urandom_range(0, 3) == 0) ? bus.req0_a : $urandom();
      bus.req0_sel = ($urandom_range(0, 1) != 0) ? ALU_SUB : ALU_ADD;
      bus.req1_a = $urandom();
      bus.req1_b = ($urandom_range(0, 3) == 0) ? bus.req1_a : $urandom();
      bus.req1_sel = ($urandom_range(0, 1) != 0) ? ALU_SUB : ALU_ADD;
      bus.resp0_ready = ($urandom_range(0, 2) != 0);
      bus.resp1_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (bus.req0_valid && bus.req1_valid) winner = !m_lg;
      else winner = bus.req1_valid;
      e_r0 = !m_busy && (winner == 1'b0);
      e_r1 = !m_busy && (winner == 1'b1);
      e_v0 = m_busy && m_age >= 2 && !m_owner;
      e_v1 = m_busy && m_age >= 2 && m_owner;
      n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== {e_r0, e_r1}) begin n_fail++; $display("FAIL rnd_ready @%0d: got %0b%0b want %0b%0b", cyc, bus.req0_ready, bus.req1_ready, e_r0, e_r1); end
      n_cmp++; if ({bus.resp0_valid, bus.resp1_valid} !== {e_v0, e_v1}) begin n_fail++; $display("FAIL rnd_resp_valid @%0d: got %0b%0b want %0b%0b", cyc, bus.resp0_valid, bus.resp1_valid, e_v0, e_v1); end
      n_cmp++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== (m_busy ? {m_a, m_b, m_sel} : '0)) begin n_fail++; $display("FAIL rnd_alu @%0d: got %0h %0h %0h busy=%0b want %0h %0h %0h", cyc, bus.alu_a, bus.alu_b, bus.alu_sel, m_busy, m_a, m_b, m_sel); end
      if (e_v0 || e_v1) begin
        n_cmp++; if ({bus.resp_zero, bus.resp_data} !== m_res) begin n_fail++; $display("FAIL rnd_resp_data @%0d: got %0h/%0b want %0h/%0b", cyc, bus.resp_data, bus.resp_zero, m_res[XLEN-1:0], m_res[XLEN]); end
      end
      if (!m_busy) begin
        if (winner ? bus.req1_valid : bus.req0_valid) begin
          m_busy = 1'b1; m_age = 1; m_owner = winner; m_lg = winner;
          m_a   = winner ? bus.req1_a : bus.req0_a;
          m_b   = winner ? bus.req1_b : bus.req0_b;
          m_sel = winner ? bus.req1_sel : bus.req0_sel;
          m_res = ref_alu(m_sel, m_a, m_b);
        end
      end else if (m_age >= 2) begin
        if (m_owner ? bus.resp1_ready : bus.resp0_ready) m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    m_lg = 1'b1;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_non_owner();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
